// File: rtl/filter_pkg.sv
// Widths shared by every filter in the ADC processing chain.
package filter_pkg;

  localparam int DEF_SIZE_ADC_DATA    = 12;
  localparam int DEF_SIZE_FILTER_DATA = 16;

endpackage

// File: rtl/trap_filter_pkg.sv
// Defaults and types for the trapezoidal shaper and its peak detector.
package trap_filter_pkg;

  localparam int DEF_K            = 8;
  localparam int DEF_L            = 12;
  localparam int DEF_SIZE_PZ_COEF = 8;
  localparam int DEF_OUT_SHIFT    = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } peak_state_t;

endpackage

// File: rtl/trap_filter_if.sv
// Sample stream, runtime controls and peak results of one trap_filter.
interface trap_filter_if #(
  parameter int SIZE_ADC_DATA    = filter_pkg::DEF_SIZE_ADC_DATA,
  parameter int SIZE_FILTER_DATA = filter_pkg::DEF_SIZE_FILTER_DATA,
  parameter int SIZE_PZ_COEF     = trap_filter_pkg::DEF_SIZE_PZ_COEF
);
  import trap_filter_pkg::*;

  // Stream contract: one input sample is taken every clock with no valid/ready
  // and no backpressure; peak_valid is a single-cycle strobe qualifying peak_data.
  logic        [SIZE_ADC_DATA-1:0]    input_data;
  logic        [SIZE_PZ_COEF-1:0]     pz_coef;
  logic signed [SIZE_FILTER_DATA-1:0] threshold;
  logic signed [SIZE_FILTER_DATA-1:0] output_data;
  logic                               peak_valid;
  logic signed [SIZE_FILTER_DATA-1:0] peak_data;
  logic        [15:0]                 event_count;
  logic                               overflow;
  peak_state_t                        pk_state;

  modport master (
    output input_data, pz_coef, threshold,
    input  output_data, peak_valid, peak_data, event_count, overflow, pk_state
  );

  modport slave (
    input  input_data, pz_coef, threshold,
    output output_data, peak_valid, peak_data, event_count, overflow, pk_state
  );

endinterface

// File: rtl/trap_filter_tap_delay_line.sv
// Shift register of depth K+L exposing the samples delayed by K, L and K+L clocks.
module trap_filter_tap_delay_line #(
  parameter int W = 12,
  parameter int K = 8,
  parameter int L = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] tap_k,
  output logic [W-1:0] tap_l,
  output logic [W-1:0] tap_kl
);

  localparam int DEPTH = K + L;

  logic [W-1:0] sr [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  // sr[j] holds din from j+1 clocks ago, so tap N sits at index N-1.
  assign tap_k  = sr[K-1];
  assign tap_l  = sr[L-1];
  assign tap_kl = sr[DEPTH-1];

endmodule

// File: rtl/trap_filter.sv
// Trapezoidal shaper with pole-zero correction, output saturation and a
// threshold peak detector that counts pulses.
module trap_filter
  import trap_filter_pkg::*;
#(
  parameter int SIZE_ADC_DATA    = filter_pkg::DEF_SIZE_ADC_DATA,
  parameter int SIZE_FILTER_DATA = filter_pkg::DEF_SIZE_FILTER_DATA,
  parameter int K                = DEF_K,
  parameter int L                = DEF_L,
  parameter int SIZE_PZ_COEF     = DEF_SIZE_PZ_COEF,
  parameter int OUT_SHIFT        = DEF_OUT_SHIFT
) (
  input logic         clk,
  input logic         reset,
  trap_filter_if.slave bus
);

  localparam int ACC_W = SIZE_ADC_DATA + SIZE_PZ_COEF + $clog2(L) + 4;
  localparam int FW    = SIZE_FILTER_DATA;

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [FW-1:0]    out_t;

  localparam acc_t OUT_MAX = {{(ACC_W-FW+1){1'b0}}, {(FW-1){1'b1}}};
  localparam acc_t OUT_MIN = {{(ACC_W-FW+1){1'b1}}, {(FW-1){1'b0}}};

  function automatic acc_t zext(input logic [SIZE_ADC_DATA-1:0] v);
    return acc_t'({{(ACC_W-SIZE_ADC_DATA){1'b0}}, v});
  endfunction

  logic [SIZE_ADC_DATA-1:0] x0, tap_k, tap_l, tap_kl;
  logic [SIZE_PZ_COEF-1:0]  m1;
  acc_t                     d, d1, p, r, s;
  acc_t                     d_next, prod, s_shift;
  out_t                     out_q, out_next;
  logic                     clip, overflow_q;

  trap_filter_tap_delay_line #(
    .W (SIZE_ADC_DATA),
    .K (K),
    .L (L)
  ) u_taps (
    .clk    (clk),
    .reset  (reset),
    .din    (x0),
    .tap_k  (tap_k),
    .tap_l  (tap_l),
    .tap_kl (tap_kl)
  );

  // Sums wrap modulo 2^ACC_W; the trapezoid relies on that cancellation.
  always_comb begin
    d_next   = zext(x0) - zext(tap_k) - zext(tap_l) + zext(tap_kl);
    prod     = {{(ACC_W-SIZE_PZ_COEF){1'b0}}, m1} * d1;
    s_shift  = s >>> OUT_SHIFT;
    clip     = 1'b0;
    out_next = s_shift[FW-1:0];
    if (s_shift > OUT_MAX) begin
      out_next = OUT_MAX[FW-1:0];
      clip     = 1'b1;
    end else if (s_shift < OUT_MIN) begin
      out_next = OUT_MIN[FW-1:0];
      clip     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      x0         <= '0;
      d          <= '0;
      d1         <= '0;
      m1         <= '0;
      p          <= '0;
      r          <= '0;
      s          <= '0;
      out_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      x0         <= bus.input_data;
      d          <= d_next;
      p          <= p + d;
      d1         <= d;
      m1         <= bus.pz_coef;
      r          <= p + prod;
      s          <= s + r;
      out_q      <= out_next;
      overflow_q <= overflow_q | clip;
    end
  end

  peak_state_t state, state_next;
  out_t        pk, pk_next, peak_data_q;
  logic        above, strobe, peak_valid_q;
  logic [15:0] event_count_q;

  assign above = out_q > bus.threshold;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (above)  state_next = ARMED;
      ARMED:   if (!above) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pk_next = pk;
    strobe  = 1'b0;
    case (state)
      IDLE:    if (above) pk_next = out_q;
      ARMED: begin
        if (!above)          strobe  = 1'b1;
        else if (out_q > pk) pk_next = out_q;
      end
      default: pk_next = pk;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pk            <= '0;
      peak_valid_q  <= 1'b0;
      peak_data_q   <= '0;
      event_count_q <= '0;
    end else begin
      pk           <= pk_next;
      peak_valid_q <= strobe;
      if (strobe) begin
        peak_data_q <= pk;
        if (event_count_q != 16'hFFFF) event_count_q <= event_count_q + 16'd1;
      end
    end
  end

  assign bus.output_data = out_q;
  assign bus.overflow    = overflow_q;
  assign bus.peak_valid  = peak_valid_q;
  assign bus.peak_data   = peak_data_q;
  assign bus.event_count = event_count_q;
  assign bus.pk_state    = state;

endmodule

// File: tb/tb_trap_filter.sv
// Randomised scoreboard bench for trap_filter against a convolution-kernel model.
module tb_trap_filter;
  import trap_filter_pkg::*;

  localparam int ADC_W     = 12;
  localparam int FW        = 16;
  localparam int CW        = 8;
  localparam int K         = 8;
  localparam int L         = 12;
  localparam int OUT_SHIFT = 0;
  localparam int ACC_W     = ADC_W + CW + $clog2(L) + 4;

  typedef struct packed {
    logic signed [FW-1:0] out;
    logic                 pv;
    logic signed [FW-1:0] pd;
    logic [15:0]          cnt;
    logic                 ovf;
  } exp_t;

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic live  = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) live <= reset;

  trap_filter_if #(.SIZE_ADC_DATA(ADC_W), .SIZE_FILTER_DATA(FW), .SIZE_PZ_COEF(CW)) bus ();

  trap_filter #(
    .SIZE_ADC_DATA    (ADC_W),
    .SIZE_FILTER_DATA (FW),
    .K                (K),
    .L                (L),
    .SIZE_PZ_COEF     (CW),
    .OUT_SHIFT        (OUT_SHIFT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // scoreboard
  exp_t   exp_q[$];
  int     vectors = 0;
  int     errors  = 0;

  // reference model state
  int     hist[$];
  int     m_cur, thr_cur;
  longint prev_out, pk, pdata;
  bit     armed, ovf;
  int     cnt;

  function automatic longint wrap_acc(longint v);
    longint m;
    m = v & ((longint'(1) << ACC_W) - 1);
    if (m >= (longint'(1) << (ACC_W - 1))) m -= (longint'(1) << ACC_W);
    return m;
  endfunction

  // Impulse response of the double-integrated shaper: rise, flat top, fall.
  function automatic int kern_t(int m);
    if (m < K) return m + 1;
    if (m < L) return K;
    return K + L - 1 - m;
  endfunction

  // Impulse response of the single integrator, weighted by the pole-zero term.
  function automatic int kern_b(int m);
    if (m < K) return 1;
    if (m < L) return 0;
    return -1;
  endfunction

  task automatic model_out(output longint o, output bit clip);
    longint acc, sh, maxv, minv;
    int n;
    acc  = 0;
    n    = hist.size() - 1;
    maxv = (longint'(1) << (FW - 1)) - 1;
    minv = -(longint'(1) << (FW - 1));
    for (int m = 0; m < K + L; m++)
      if (n - m >= 0) acc += longint'(hist[n-m]) * (kern_t(m) + m_cur * kern_b(m));
    acc  = wrap_acc(acc);
    sh   = acc >>> OUT_SHIFT;
    clip = 1'b0;
    o    = sh;
    if (sh > maxv) begin o = maxv; clip = 1'b1; end
    else if (sh < minv) begin o = minv; clip = 1'b1; end
  endtask

  // One record per clock: the output of that cycle plus the peak decision
  // taken on the same edge from the previous cycle's output.
  task automatic push_record(longint o, bit clip);
    exp_t e;
    e.pv = 1'b0;
    if (!armed) begin
      if (prev_out > thr_cur) begin armed = 1'b1; pk = prev_out; end
    end else if (prev_out <= thr_cur) begin
      e.pv  = 1'b1;
      pdata = pk;
      armed = 1'b0;
      if (cnt < 65535) cnt++;
    end else if (prev_out > pk) begin
      pk = prev_out;
    end
    ovf   = ovf | clip;
    e.out = o[FW-1:0];
    e.pd  = pdata[FW-1:0];
    e.cnt = cnt[15:0];
    e.ovf = ovf;
    exp_q.push_back(e);
    prev_out = o;
  endtask

  task automatic check_val(string name, longint act, longint req);
    vectors++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // driver tasks
  task automatic drive(int x);
    longint o;
    bit     clip;
    bus.input_data = x[ADC_W-1:0];
    hist.push_back(x);
    model_out(o, clip);
    push_record(o, clip);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int m, int thr);
    reset          = 1'b0;
    bus.input_data = '0;
    bus.pz_coef    = m[CW-1:0];
    bus.threshold  = thr[FW-1:0];
    @(posedge clk);
    #1;
    check_val("reset output_data", bus.output_data, 0);
    check_val("reset peak_valid", bus.peak_valid, 0);
    check_val("reset peak_data", bus.peak_data, 0);
    check_val("reset event_count", bus.event_count, 0);
    check_val("reset overflow", bus.overflow, 0);
    check_val("reset pk_state", bus.pk_state, IDLE);
    reset = 1'b1;
    hist.delete();
    exp_q.delete();
    m_cur    = m;
    thr_cur  = thr;
    prev_out = 0;
    pk       = 0;
    pdata    = 0;
    armed    = 1'b0;
    ovf      = 1'b0;
    cnt      = 0;
    // five cycles of pipeline fill precede the first shaped sample
    repeat (5) push_record(0, 1'b0);
  endtask

  // monitor
  exp_t mon_e;
  always @(negedge clk) begin
    if (live) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stream underflow: DUT output %0d with no expected record", bus.output_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.output_data !== mon_e.out || bus.peak_valid !== mon_e.pv ||
            bus.peak_data !== mon_e.pd || bus.event_count !== mon_e.cnt ||
            bus.overflow !== mon_e.ovf) begin
          errors++;
          $display("FAIL stream @%0t: got out=%0d pv=%0b pd=%0d cnt=%0d ovf=%0b, expected out=%0d pv=%0b pd=%0d cnt=%0d ovf=%0b",
                   $time, bus.output_data, bus.peak_valid, bus.peak_data, bus.event_count, bus.overflow,
                   mon_e.out, mon_e.pv, mon_e.pd, mon_e.cnt, mon_e.ovf);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int x;
    bus.input_data = '0;
    bus.pz_coef    = '0;
    bus.threshold  = '0;
    repeat (2) @(posedge clk);
    #1;

    // single impulse: trapezoid 100..800, flat, 700..0; one peak of 800
    do_reset(0, 400);
    drive(100);
    repeat (30) drive(0);
    check_val("impulse peak_data", bus.peak_data, 800);
    check_val("impulse event_count", bus.event_count, 1);

    // pile-up of two impulses six samples apart merges into one pulse
    do_reset(0, 400);
    drive(100);
    repeat (5) drive(0);
    drive(100);
    repeat (30) drive(0);
    check_val("pileup peak_data", bus.peak_data, 1400);
    check_val("pileup event_count", bus.event_count, 1);

    // reset in the middle of a pulse, then the same impulse again
    do_reset(0, 400);
    drive(100);
    repeat (13) drive(0);
    do_reset(0, 400);
    drive(100);
    repeat (30) drive(0);
    check_val("rerun peak_data", bus.peak_data, 800);
    check_val("rerun event_count", bus.event_count, 1);

    // full-scale block drives the accumulator far past the output range
    do_reset(0, 400);
    repeat (20) drive(4095);
    repeat (30) drive(0);
    check_val("saturation overflow sticky", bus.overflow, 1);

    // exponential tail with matching pole-zero coefficient
    do_reset(16, 1000);
    x = 150;
    repeat (60) begin
      drive(x);
      x = x - x / 16;
    end
    repeat (30) drive(0);

    // randomised sections: sparse impulses, exponential pulses, full noise
    for (int r = 0; r < 9; r++) begin
      int m, thr, mode;
      m    = (r % 3 == 0) ? 0 : (r % 3 == 1) ? 16 : int'($urandom_range(0, 255));
      thr  = int'($urandom_range(0, 4000)) - 1500;
      mode = int'($urandom_range(0, 2));
      do_reset(m, thr);
      x = 0;
      for (int i = 0; i < 80; i++) begin
        case (mode)
          0:       x = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 600)) : 0;
          1:       x = ($urandom_range(0, 19) == 0) ? int'($urandom_range(50, 400)) : x - x / 16;
          default: x = int'($urandom_range(0, 4095));
        endcase
        drive(x);
      end
      repeat (30) drive(0);
    end

    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check_val("drain remaining records", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
